// File: rtl/jk_reg_bank.sv
// Bank of WIDTH flip-flops with runtime JK/D/T/SR mode, edge pulses, a sticky SR illegal flag and a saturating change counter.
// Latency: one edge to every registered output. There is no backpressure: each enabled edge is an update.
module jk_reg_bank #(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}},
    parameter int                 CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  j,
    input  logic [WIDTH-1:0]  k,
    input  logic              illegal_clr,
    input  logic              cnt_clr,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qn,
    output logic [WIDTH-1:0]  rise,
    output logic [WIDTH-1:0]  fall,
    output logic              illegal,
    output logic [CNT_W-1:0]  chg_cnt
);

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_D  = 2'b01,
        MODE_T  = 2'b10,
        MODE_SR = 2'b11
    } mode_t;

    logic [WIDTH-1:0] q_nx;
    logic             sr_bad;
    logic             q_chg;
    logic             cnt_sat;

    // SR: S=R=1 holds, like 00, so the hold term covers every j==k case.
    always_comb begin
        q_nx   = q;
        sr_bad = 1'b0;
        unique case (mode_t'(mode))
            MODE_JK: q_nx = (j & ~q) | (~k & q);
            MODE_D:  q_nx = j;
            MODE_T:  q_nx = q ^ j;
            MODE_SR: begin
                q_nx   = (j & ~k) | (q & ~(j ^ k));
                sr_bad = |(j & k);
            end
            default: q_nx = q;
        endcase
    end

    assign q_chg   = (q_nx != q);
    assign cnt_sat = &chg_cnt;
    assign qn      = ~q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q       <= RST_VAL;
            rise    <= '0;
            fall    <= '0;
            illegal <= 1'b0;
            chg_cnt <= '0;
        end else begin
            if (en) begin
                q    <= q_nx;
                rise <= ~q & q_nx;
                fall <= q & ~q_nx;
            end else begin
                rise <= '0;
                fall <= '0;
            end

            // A set on the same edge as a clear wins.
            if (en && sr_bad)
                illegal <= 1'b1;
            else if (illegal_clr)
                illegal <= 1'b0;

            if (cnt_clr)
                chg_cnt <= '0;
            else if (en && q_chg && !cnt_sat)
                chg_cnt <= chg_cnt + 1'b1;
        end
    end

endmodule
